// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone classic initiator.
// State encoding, beat stride and default ack timeout.
package wb_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_WD = 2'd1,
      ST_BUS     = 2'd2,
      ST_RESP    = 2'd3
   } wbm_state_e;

   localparam int WB_DATA_W  = 32;
   localparam int WB_STRIDE  = WB_DATA_W / 8;
   localparam int WB_TIMEOUT = 255;

   function automatic int wb_stride(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/wb_master_seq_tmo.sv
// Ack timeout counter for one bus beat.
// expired_o flags the cycle that would be the TIMEOUT-th without ack.
module wb_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

   // Clear on beat start, count wait cycles, hold once expired
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_master_seq.sv
// Wishbone classic initiator: cmd/wdata requests become single or
// incrementing-burst bus cycles with one response per beat.
module wb_master_seq
   import wb_master_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = WB_TIMEOUT
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_we_i,
   input  logic [ADDR_W-1:0]   cmd_adr_i,
   input  logic [DATA_W/8-1:0] cmd_sel_i,
   input  logic [LEN_W-1:0]    cmd_len_i,
   input  logic                wdat_valid_i,
   output logic                wdat_ready_o,
   input  logic [DATA_W-1:0]   wdat_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DATA_W-1:0]   rsp_dat_o,
   output logic                rsp_err_o,
   output logic                rsp_last_o,
   output logic                busy_o,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [DATA_W/8-1:0] wbm_sel_o,
   output logic [ADDR_W-1:0]   wbm_adr_o,
   output logic [DATA_W-1:0]   wbm_dat_o,
   input  logic                wbm_ack_i,
   input  logic [DATA_W-1:0]   wbm_dat_i
);

   localparam int SEL_W  = DATA_W / 8;
   localparam int STRIDE = wb_stride(DATA_W);

   wbm_state_e          state_q, state_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                wdat_ready_q, wdat_ready_d;
   logic                busy_q, busy_d;
   logic                cyc_q, cyc_d;
   logic                we_q, we_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [ADDR_W-1:0]   adr_q, adr_d;
   logic [DATA_W-1:0]   dat_q, dat_d;
   logic [LEN_W-1:0]    beats_q, beats_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_last_q, rsp_last_d;

   logic                tmo_clr;
   logic                tmo_en;
   logic                tmo_exp;

   assign tmo_clr = (state_q != ST_BUS) && (state_d == ST_BUS);
   assign tmo_en  = (state_q == ST_BUS) && !wbm_ack_i;

   wb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .clr_i     (tmo_clr),
      .en_i      (tmo_en),
      .expired_o (tmo_exp)
   );

   // Next state, latched command/beat data and registered outputs
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      beats_d     = beats_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      rsp_last_d  = rsp_last_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i && cmd_ready_q) begin
               adr_d   = cmd_adr_i;
               sel_d   = cmd_sel_i;
               we_d    = cmd_we_i;
               beats_d = cmd_len_i;
               state_d = cmd_we_i ? ST_WAIT_WD : ST_BUS;
            end
         end
         ST_WAIT_WD: begin
            if (wdat_valid_i && wdat_ready_q) begin
               dat_d   = wdat_i;
               state_d = ST_BUS;
            end
         end
         ST_BUS: begin
            if (wbm_ack_i) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = we_q ? '0 : wbm_dat_i;
               rsp_err_d   = 1'b0;
               rsp_last_d  = (beats_q == '0);
            end else if (tmo_exp) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = '0;
               rsp_err_d   = 1'b1;
               rsp_last_d  = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               rsp_dat_d   = '0;
               rsp_err_d   = 1'b0;
               rsp_last_d  = 1'b0;
               if (rsp_err_q || rsp_last_q) begin
                  state_d = ST_IDLE;
               end else begin
                  adr_d   = adr_q + ADDR_W'(STRIDE);
                  beats_d = beats_q - LEN_W'(1);
                  state_d = we_q ? ST_WAIT_WD : ST_BUS;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      cmd_ready_d  = (state_d == ST_IDLE);
      wdat_ready_d = (state_d == ST_WAIT_WD);
      cyc_d        = (state_d == ST_BUS);
      busy_d       = (state_d != ST_IDLE);
   end

   // State and output registers; reset drops the bus immediately
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q      <= ST_IDLE;
         cmd_ready_q  <= 1'b1;
         wdat_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         sel_q        <= '0;
         adr_q        <= '0;
         dat_q        <= '0;
         beats_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_dat_q    <= '0;
         rsp_err_q    <= 1'b0;
         rsp_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         wdat_ready_q <= wdat_ready_d;
         busy_q       <= busy_d;
         cyc_q        <= cyc_d;
         we_q         <= we_d;
         sel_q        <= sel_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         beats_q      <= beats_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_dat_q    <= rsp_dat_d;
         rsp_err_q    <= rsp_err_d;
         rsp_last_q   <= rsp_last_d;
      end
   end

   assign cmd_ready_o  = cmd_ready_q;
   assign wdat_ready_o = wdat_ready_q;
   assign busy_o       = busy_q;
   assign wbm_cyc_o    = cyc_q;
   assign wbm_stb_o    = cyc_q;
   assign wbm_we_o     = we_q;
   assign wbm_sel_o    = sel_q;
   assign wbm_adr_o    = adr_q;
   assign wbm_dat_o    = dat_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_dat_o    = rsp_dat_q;
   assign rsp_err_o    = rsp_err_q;
   assign rsp_last_o   = rsp_last_q;

endmodule

// File: tb/tb_wb_master_seq.sv
// Bench for wb_master_seq: directed scenarios plus random bursts
// against a beat-level reference model and a latency-programmable slave.
module tb_wb_master_seq;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr;
   logic [3:0]  cmd_sel;
   logic [7:0]  cmd_len;
   logic        wdat_valid, wdat_ready;
   logic [31:0] wdat;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_last;
   logic [31:0] rsp_dat;
   logic        busy, cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o, dat_i;
   logic        ack;

   always #5 clk = ~clk;

   wb_master_seq #(
      .ADDR_W (32), .DATA_W (32), .LEN_W (8), .TIMEOUT (TO)
   ) dut (
      .wb_clk_i (clk), .wb_rst_ni (rst_n),
      .cmd_valid_i (cmd_valid), .cmd_ready_o (cmd_ready),
      .cmd_we_i (cmd_we), .cmd_adr_i (cmd_adr),
      .cmd_sel_i (cmd_sel), .cmd_len_i (cmd_len),
      .wdat_valid_i (wdat_valid), .wdat_ready_o (wdat_ready),
      .wdat_i (wdat),
      .rsp_valid_o (rsp_valid), .rsp_ready_i (rsp_ready),
      .rsp_dat_o (rsp_dat), .rsp_err_o (rsp_err),
      .rsp_last_o (rsp_last), .busy_o (busy),
      .wbm_cyc_o (cyc), .wbm_stb_o (stb), .wbm_we_o (we),
      .wbm_sel_o (sel), .wbm_adr_o (adr), .wbm_dat_o (dat_o),
      .wbm_ack_i (ack), .wbm_dat_i (dat_i)
   );

   int ncmp = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
   } beat_t;

   int          lat = 1;
   bit          noack = 1'b0;
   bit          ovr = 1'b0;
   logic [31:0] ovr_val = 32'h0;
   int          run = 0;
   beat_t       blog[$];
   int          lens[$];

   function automatic logic [31:0] rdf(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   // Slave: acks in the lat-th cycle of cyc, logs beats and cyc lengths,
   // throws stray acks while no cycle is open.
   initial begin
      ack = 1'b0;
      dat_i = '0;
      forever begin
         @(posedge clk);
         #1;
         if (cyc) begin
            run++;
            if (!noack && run == lat) begin
               ack = 1'b1;
               dat_i = ovr ? ovr_val : rdf(adr);
               blog.push_back('{adr, we, sel, we ? dat_o : dat_i});
            end else begin
               ack = 1'b0;
               dat_i = $urandom;
            end
         end else begin
            if (run > 0) lens.push_back(run);
            run = 0;
            ack = ($urandom_range(0, 3) == 0);
            dat_i = $urandom;
         end
      end
   end

   task automatic do_cmd(input logic c_we, input logic [31:0] c_adr,
                         input logic [3:0] c_sel, input logic [7:0] c_len,
                         input int l, input bit na, input bit incwd,
                         input int smin, input int smax);
      int          n = int'(c_len) + 1;
      logic [31:0] wd[$];
      beat_t       eb[$];
      logic [31:0] a, ed;
      int          wb = 0;
      int          r = 0;
      int          st;
      int          guard = 0;
      bit          done = 1'b0;
      bit          el;
      lat = l;
      noack = na;
      blog.delete();
      lens.delete();
      for (int i = 0; i < n; i++) begin
         wd.push_back(incwd ? 32'(i + 1) : $urandom);
      end
      for (int i = 0; i < n; i++) begin
         a = c_adr + 32'(4 * i);
         eb.push_back('{a, c_we, c_sel,
                        c_we ? wd[i] : (ovr ? ovr_val : rdf(a))});
      end
      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_we = c_we;
      cmd_adr = c_adr;
      cmd_sel = c_sel;
      cmd_len = c_len;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_adr = $urandom;
      chk("busy_after_accept", busy, 1);
      chk("cmd_ready_busy", cmd_ready, 0);
      st = $urandom_range(smin, smax);
      while (!done && guard < 3000) begin
         guard++;
         chk("stb_eq_cyc", stb, cyc);
         wdat_valid = (wb < n);
         if (wb < n) wdat = wd[wb];
         if (wdat_ready && wdat_valid) wb++;
         if (rsp_valid) begin
            chk("no_cyc_while_rsp", cyc, 0);
            ed = (na || c_we || r >= n) ? 32'h0 : eb[r].dat;
            el = na || (r == n - 1);
            chk("rsp_dat", rsp_dat, ed);
            chk("rsp_err", rsp_err, na);
            chk("rsp_last", rsp_last, el);
            if (st > 0) begin
               rsp_ready = 1'b0;
               st--;
            end else begin
               rsp_ready = 1'b1;
               r++;
               st = $urandom_range(smin, smax);
               if (na || el) done = 1'b1;
            end
         end else begin
            rsp_ready = 1'b0;
         end
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      wdat_valid = 1'b0;
      chk("cmd_completed", done, 1);
      chk("idle_busy", busy, 0);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("rsp_count", r, na ? 1 : n);
      chk("wdat_taken", wb, c_we ? (na ? 1 : n) : 0);
      chk("bus_beats", blog.size(), na ? 0 : n);
      for (int i = 0; i < blog.size() && i < n; i++) begin
         chk("beat_adr", blog[i].adr, eb[i].adr);
         chk("beat_we", blog[i].we, eb[i].we);
         chk("beat_sel", blog[i].sel, eb[i].sel);
         chk("beat_dat", blog[i].dat, eb[i].dat);
      end
      chk("cyc_count", lens.size(), na ? 1 : n);
      for (int i = 0; i < lens.size(); i++) begin
         chk("cyc_len", lens[i], na ? TO : l);
      end
   endtask

   initial begin
      int g;
      cmd_valid = 1'b0;
      cmd_we = 1'b0;
      cmd_adr = '0;
      cmd_sel = '0;
      cmd_len = '0;
      wdat_valid = 1'b0;
      wdat = '0;
      rsp_ready = 1'b0;

      #12;
      chk("rst_cyc", cyc, 0);
      chk("rst_stb", stb, 0);
      chk("rst_we", we, 0);
      chk("rst_adr", adr, 0);
      chk("rst_sel", sel, 0);
      chk("rst_dat", dat_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_dat", rsp_dat, 0);
      chk("rst_wdat_ready", wdat_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_cmd_ready", cmd_ready, 1);

      ovr = 1'b1;
      ovr_val = 32'hDEAD_BEEF;
      do_cmd(1'b0, 32'h3000_0000, 4'hF, 8'd0, 3, 1'b0, 1'b0, 0, 0);
      ovr = 1'b0;

      do_cmd(1'b1, 32'h3000_0010, 4'hF, 8'd3, 2, 1'b0, 1'b1, 0, 1);

      do_cmd(1'b0, 32'h3000_0100, 4'hF, 8'd3, 1, 1'b1, 1'b0, 0, 0);

      do_cmd(1'b0, 32'h3000_0200, 4'h3, 8'd1, 1, 1'b0, 1'b0, 10, 10);

      do_cmd(1'b1, 32'h3000_0300, 4'hC, 8'd3, 1, 1'b1, 1'b0, 0, 0);

      noack = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_we = 1'b1;
      cmd_adr = 32'h3000_0400;
      cmd_sel = 4'hF;
      cmd_len = 8'd3;
      wdat_valid = 1'b1;
      wdat = 32'h1234_5678;
      @(negedge clk);
      cmd_valid = 1'b0;
      g = 0;
      while (!cyc && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk("rstmid_cyc_up", cyc, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_cyc", cyc, 0);
      chk("rstmid_stb", stb, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wdat_valid = 1'b0;
      @(negedge clk);
      chk("rstmid_cmd_ready", cmd_ready, 1);
      chk("rstmid_cyc_after", cyc, 0);
      noack = 1'b0;

      do_cmd(1'b0, 32'hFFFF_FFFC, 4'hF, 8'd1, 2, 1'b0, 1'b0, 0, 1);
      do_cmd(1'b0, 32'h3000_0500, 4'hF, 8'd0, TO, 1'b0, 1'b0, 0, 0);
      do_cmd(1'b1, 32'h3000_0600, 4'h5, 8'd1, TO, 1'b0, 1'b0, 0, 0);

      for (int k = 0; k < 25; k++) begin
         logic        rwe;
         logic [31:0] radr;
         logic [3:0]  rsel;
         logic [7:0]  rlen;
         int          rlat;
         bit          rna;
         rwe = 1'($urandom_range(0, 1));
         radr = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) radr = radr | 32'hFFFF_FFE0;
         rsel = 4'($urandom_range(0, 15));
         rlen = 8'($urandom_range(0, 5));
         rlat = $urandom_range(1, TO);
         rna = ($urandom_range(0, 7) == 0);
         do_cmd(rwe, radr, rsel, rlen, rlat, rna, 1'b0, 0, 3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
